// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display blocks.
//   - Active-high glyph constants for hex digits 0-F plus SEG_OFF.
//     Bit order is seg[0]=a .. seg[6]=g.
//   - nibble_to_glyph(): pure nibble -> active-high glyph lookup.
//   - clog2_min1(): ceiling log2 with a floor of 1.
//     Used to size index and counter registers from parameters.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [6:0] GLYPH_0 = 7'b0111111;
    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] GLYPH_7 = 7'b0000111;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1101111;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b1111100;
    localparam logic [6:0] GLYPH_C = 7'b0111001;
    localparam logic [6:0] GLYPH_D = 7'b1011110;
    localparam logic [6:0] GLYPH_E = 7'b1111001;
    localparam logic [6:0] GLYPH_F = 7'b1110001;

    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

    // Smallest width able to hold the values 0..value-1.
    // The result is never less than 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational nibble -> active-high 7-segment glyph.
//   nibble_i [3:0]  value 0-F
//   glyph_o  [6:0]  active-high segments, glyph_o[0]=a .. glyph_o[6]=g
// Polarity is left to the instantiating block so this decoder can be shared.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = nibble_to_glyph(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit 7-segment display.
//
// Ports:
//   clk_i          system clock; all logic is on the rising edge
//   rst_n_i        synchronous active-low reset
//   en_i           scan enable
//   load_i         capture bcd_in_i into the display register on this edge
//   bcd_in_i       packed nibbles; digit 0 is in bits [3:0] and is the rightmost digit
//   blank_mask_i   per digit: 1 forces the digit dark; sampled live
//   seg_o          segments, seg_o[0]=a .. seg_o[6]=g, registered
//   an_o           one-hot digit select, registered
//   digit_idx_o    currently selected digit, registered
//
// Each digit slot lasts SCAN_DIV clocks. The slot starts with one dead clock
// (prescaler==0) in which every output is off, which avoids ghosting.
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, leading zeros are blanked; digit 0 always shows.
//   Leading zeros are detected from the display register.
//
// Output registers are loaded from the next-state values of prescaler,
// digit index and display register. The pins therefore always describe the
// state those registers hold after the same edge.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 en_i,
    input  logic                                 load_i,
    input  logic [4*NUM_DIGITS-1:0]              bcd_in_i,
    input  logic [NUM_DIGITS-1:0]                blank_mask_i,
    output logic [6:0]                           seg_o,
    output logic [NUM_DIGITS-1:0]                an_o,
    output logic [clog2_min1(NUM_DIGITS)-1:0]    digit_idx_o
);

    localparam int DIDX_W = clog2_min1(NUM_DIGITS);
    localparam int PS_W   = clog2_min1(SCAN_DIV);

    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [DIDX_W-1:0]     IDX_LAST = DIDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? '1 : '0;

    logic [PS_W-1:0]         prescaler_q, prescaler_d;
    logic [DIDX_W-1:0]       digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q,      disp_d;
    logic [6:0]              seg_q,       seg_d;
    logic [NUM_DIGITS-1:0]   an_q,        an_d;

    logic                    tick;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic [6:0]              cur_glyph;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   blank_eff;

    assign tick = en_i && (prescaler_q == PS_LAST);

    // Scan counters and display register.
    always_comb begin
        disp_d      = load_i ? bcd_in_i : disp_q;
        prescaler_d = prescaler_q;
        digit_idx_d = digit_idx_q;
        if (en_i) begin
            if (tick) begin
                prescaler_d = '0;
                digit_idx_d = (digit_idx_q == IDX_LAST) ? '0
                                                        : digit_idx_q + DIDX_W'(1);
            end else begin
                prescaler_d = prescaler_q + PS_W'(1);
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero if it and every more-significant digit is 0.
    // Digit 0 is never suppressed, so a value of all zeros still shows "0".
    // disp_d is used because it is the register content the outputs reflect.
    logic higher_zero;
    always_comb begin
        lz_blank    = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (disp_d[4*i +: 4] == 4'd0);
            lz_blank[i] = higher_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign blank_eff = blank_mask_i | lz_blank;

    // Select the nibble and blank flag of the digit that is shown next.
    always_comb begin
        cur_nibble = 4'd0;
        cur_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_d == DIDX_W'(i)) begin
                cur_nibble = disp_d[4*i +: 4];
                cur_blank  = blank_eff[i];
            end
        end
    end

    seg7_glyph_decode u_decode (
        .nibble_i (cur_nibble),
        .glyph_o  (cur_glyph)
    );

    // Active-high output values; the dead clock and en_i=0 give all off.
    // A blanked digit keeps its anode driven but shows no segments.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '0;
        if (en_i && (prescaler_d != '0)) begin
            an_d = NUM_DIGITS'(1) << digit_idx_d;
            if (!cur_blank) begin
                seg_d = cur_glyph;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            disp_q      <= '0;
            seg_q       <= SEG_IDLE;
            an_q        <= AN_IDLE;
        end else begin
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            disp_q      <= disp_d;
            seg_q       <= SEG_ACT_LOW ? ~seg_d : seg_d;
            an_q        <= AN_ACT_LOW ? ~an_d : an_d;
        end
    end

    assign seg_o       = seg_q;
    assign an_o        = an_q;
    assign digit_idx_o = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver.
//   dut  : NUM_DIGITS=4, SCAN_DIV=4, active-high segments and anodes.
//   dut1 : NUM_DIGITS=1, SCAN_DIV=2, active-low segments and anodes.
//          dut1 is used for the full glyph sweep.
// Expected leading-zero results follow SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  idx;

    logic        rst1_n, en1, load1;
    logic [3:0]  bcd1;
    logic [0:0]  blank1;
    logic [6:0]  seg1;
    logic [0:0]  an1;
    logic [0:0]  idx1;

    int checks = 0;
    int errors = 0;

    // Active-high glyph table {g..a}, entered by hand from the display datasheet
    logic [6:0] gl [0:15];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_i(load),
        .bcd_in_i(bcd), .blank_mask_i(blank),
        .seg_o(seg), .an_o(an), .digit_idx_o(idx)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(1), .SCAN_DIV(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_n_i(rst1_n), .en_i(en1), .load_i(load1),
        .bcd_in_i(bcd1), .blank_mask_i(blank1),
        .seg_o(seg1), .an_o(an1), .digit_idx_o(idx1)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; blank = 4'b0; bcd = 16'h0;
        clk_step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b1; bcd = 16'hFFFF; blank = 4'b0;
        repeat (3) clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd0}) begin
            errors++;
            $display("FAIL reset_hold: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=0", an, seg, idx);
        end
        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd0}) begin
            errors++;
            $display("FAIL reset_release: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=0", an, seg, idx);
        end
        // Display register must have been cleared despite load being held during reset
        en = 1'b1;
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0001, 7'b0111111, 2'd0}) begin
            errors++;
            $display("FAIL reset_disp_zero: an=%b seg=%b idx=%0d expected an=0001 seg=0111111 idx=0", an, seg, idx);
        end
    endtask

    task automatic test_scan();
        int digs [0:3];
        logic [3:0] ea;
        logic [6:0] es;
        digs = '{4, 3, 2, 1};
        do_reset();
        bcd = 16'h1234; load = 1'b1; en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            int d;
            d = s % 4;
            if (s > 0) begin
                clk_step();
                checks++;
                if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'(d)}) begin
                    errors++;
                    $display("FAIL scan_dead slot %0d: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=%0d", s, an, seg, idx, d);
                end
            end
            ea = 4'b0001 << d;
            es = gl[digs[d]];
            for (int k = 0; k < 3; k++) begin
                clk_step();
                load = 1'b0;
                checks++;
                if ({an, seg, idx} !== {ea, es, 2'(d)}) begin
                    errors++;
                    $display("FAIL scan_on slot %0d clk %0d: an=%b seg=%b idx=%0d expected an=%b seg=%b idx=%0d", s, k, an, seg, idx, ea, es, d);
                end
            end
        end
    endtask

    task automatic test_glyph_sweep();
        rst1_n = 1'b0; en1 = 1'b0; load1 = 1'b0; bcd1 = 4'h0; blank1 = 1'b0;
        clk_step();
        checks++;
        if ({an1, seg1, idx1} !== {1'b1, 7'b1111111, 1'b0}) begin
            errors++;
            $display("FAIL sweep_reset: an=%b seg=%b idx=%0d expected an=1 seg=1111111 idx=0", an1, seg1, idx1);
        end
        rst1_n = 1'b1; en1 = 1'b1;
        for (int v = 0; v < 16; v++) begin
            load1 = 1'b1; bcd1 = 4'(v);
            clk_step();
            load1 = 1'b0;
            checks++;
            if ({an1, seg1, idx1} !== {1'b0, ~gl[v], 1'b0}) begin
                errors++;
                $display("FAIL sweep_glyph %0d: an=%b seg=%b idx=%0d expected an=0 seg=%b idx=0", v, an1, seg1, idx1, ~gl[v]);
            end
            clk_step();
            checks++;
            if ({an1, seg1, idx1} !== {1'b1, 7'b1111111, 1'b0}) begin
                errors++;
                $display("FAIL sweep_dead %0d: an=%b seg=%b idx=%0d expected an=1 seg=1111111 idx=0", v, an1, seg1, idx1);
            end
        end
        en1 = 1'b0;
    endtask

    task automatic test_blank_and_en();
        do_reset();
        blank = 4'b0100; bcd = 16'h1234; load = 1'b1; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clk_step();
            load = 1'b0;
        end
        checks++;
        if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd2}) begin
            errors++;
            $display("FAIL blank_dead: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=2", an, seg, idx);
        end
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0100, 7'b0000000, 2'd2}) begin
            errors++;
            $display("FAIL blank_digit2: an=%b seg=%b idx=%0d expected an=0100 seg=0000000 idx=2", an, seg, idx);
        end
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clk_step();
            checks++;
            if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd2}) begin
                errors++;
                $display("FAIL en_off clk %0d: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=2", k, an, seg, idx);
            end
        end
        en = 1'b1; blank = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            clk_step();
            checks++;
            if ({an, seg, idx} !== {4'b0100, 7'b1011011, 2'd2}) begin
                errors++;
                $display("FAIL en_resume clk %0d: an=%b seg=%b idx=%0d expected an=0100 seg=1011011 idx=2", k, an, seg, idx);
            end
        end
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd3}) begin
            errors++;
            $display("FAIL en_resume_wrap: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=3", an, seg, idx);
        end
    endtask

    task automatic test_mid_scan();
        do_reset();
        bcd = 16'h1234; load = 1'b1; en = 1'b1;
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0001, 7'b1100110, 2'd0}) begin
            errors++;
            $display("FAIL mid_first: an=%b seg=%b idx=%0d expected an=0001 seg=1100110 idx=0", an, seg, idx);
        end
        bcd = 16'h9999;
        clk_step();
        load = 1'b0;
        checks++;
        if ({an, seg, idx} !== {4'b0001, 7'b1101111, 2'd0}) begin
            errors++;
            $display("FAIL mid_load: an=%b seg=%b idx=%0d expected an=0001 seg=1101111 idx=0", an, seg, idx);
        end
        repeat (3) clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0010, 7'b1101111, 2'd1}) begin
            errors++;
            $display("FAIL mid_next_digit: an=%b seg=%b idx=%0d expected an=0010 seg=1101111 idx=1", an, seg, idx);
        end
        rst_n = 1'b0; load = 1'b1; bcd = 16'h1234;
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=0", an, seg, idx);
        end
        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        clk_step();
        en = 1'b1;
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0001, 7'b0111111, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset_disp: an=%b seg=%b idx=%0d expected an=0001 seg=0111111 idx=0", an, seg, idx);
        end
        // Load while disabled still updates the display register
        en = 1'b0; load = 1'b1; bcd = 16'h8765;
        clk_step();
        load = 1'b0; en = 1'b1;
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0001, 7'b1101101, 2'd0}) begin
            errors++;
            $display("FAIL load_while_disabled: an=%b seg=%b idx=%0d expected an=0001 seg=1101101 idx=0", an, seg, idx);
        end
    endtask

    task automatic test_load_tick();
        do_reset();
        bcd = 16'h1234; load = 1'b1; en = 1'b1;
        clk_step();
        load = 1'b0;
        repeat (2) clk_step();
        load = 1'b1; bcd = 16'h5678;
        clk_step();
        load = 1'b0;
        checks++;
        if ({an, seg, idx} !== {4'b0000, 7'b0000000, 2'd1}) begin
            errors++;
            $display("FAIL load_tick_dead: an=%b seg=%b idx=%0d expected an=0000 seg=0000000 idx=1", an, seg, idx);
        end
        clk_step();
        checks++;
        if ({an, seg, idx} !== {4'b0010, 7'b0000111, 2'd1}) begin
            errors++;
            $display("FAIL load_tick_new: an=%b seg=%b idx=%0d expected an=0010 seg=0000111 idx=1", an, seg, idx);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_a [0:3];
        logic [6:0] exp_z [0:3];
        logic [3:0] ea;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_a = '{gl[0], gl[5], 7'h00, 7'h00};
        exp_z = '{gl[0], 7'h00, 7'h00, 7'h00};
`else
        exp_a = '{gl[0], gl[5], gl[0], gl[0]};
        exp_z = '{gl[0], gl[0], gl[0], gl[0]};
`endif
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            bcd = (pass == 0) ? 16'h0050 : 16'h0000;
            load = 1'b1; en = 1'b1;
            for (int d = 0; d < 4; d++) begin
                if (d == 0) clk_step();
                else repeat (4) clk_step();
                load = 1'b0;
                ea = 4'b0001 << d;
                checks++;
                if ((pass == 0 && {an, seg, idx} !== {ea, exp_a[d], 2'(d)}) ||
                    (pass == 1 && {an, seg, idx} !== {ea, exp_z[d], 2'(d)})) begin
                    errors++;
                    $display("FAIL leading_zero pass %0d digit %0d: an=%b seg=%b idx=%0d expected an=%b seg=%b idx=%0d",
                             pass, d, an, seg, idx, ea, (pass == 0) ? exp_a[d] : exp_z[d], d);
                end
            end
        end
    endtask

    initial begin
        gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd = 16'h0; blank = 4'b0;
        rst1_n = 1'b0; en1 = 1'b0; load1 = 1'b0; bcd1 = 4'h0; blank1 = 1'b0;
        test_reset();
        test_scan();
        test_glyph_sweep();
        test_blank_and_en();
        test_mid_scan();
        test_load_tick();
        test_leading_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
